// File: rtl/key_event_sched_if.sv
// Key-channel inputs and event output port of key_event_sched, plus debug visibility of
// the per-key FSMs and the round-robin pointer.
interface key_event_sched_if #(
    parameter int NKEYS = 4,
    parameter int KEY_W = 2
);
    logic [NKEYS-1:0]   key_flag;
    logic [NKEYS-1:0]   key_state;
    // Handshake: an event transfers on any edge where ev_valid & ev_ready; while
    // ev_valid & !ev_ready the producer holds ev_key/ev_type stable, and it never drops
    // ev_valid without a transfer.
    logic               ev_valid;
    logic               ev_ready;
    logic [KEY_W-1:0]   ev_key;
    logic [1:0]         ev_type;
    logic               ovf;
    logic               ovf_clr;
    logic [2*NKEYS-1:0] dbg_fsm;
    logic [KEY_W-1:0]   dbg_rr_ptr;

    modport master (
        input  key_flag, key_state, ev_ready, ovf_clr,
        output ev_valid, ev_key, ev_type, ovf, dbg_fsm, dbg_rr_ptr
    );

    modport slave (
        output key_flag, key_state, ev_ready, ovf_clr,
        input  ev_valid, ev_key, ev_type, ovf, dbg_fsm, dbg_rr_ptr
    );
endinterface

// File: rtl/key_event_sched.sv
// Classifies debounced key presses as SHORT / LONG / LONG_REL per key. It holds one
// pending event per key and serialises the pending events round-robin onto a single
// valid/ready port.
module key_event_sched #(
    parameter int NKEYS    = 4,
    parameter int KEY_W    = 2,
    parameter int LONG_CNT = 25_000_000,
    parameter int CNT_W    = 25
) (
    input logic                Clk,
    input logic                Rst_n,
    key_event_sched_if.master  bus
);
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PRESSED = 2'd1,
        ST_HELD    = 2'd2
    } key_st_e;

    localparam logic [1:0]       EV_SHORT    = 2'b01;
    localparam logic [1:0]       EV_LONG     = 2'b10;
    localparam logic [1:0]       EV_LONG_REL = 2'b11;
    localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_CNT - 1);

    key_st_e          st_q [NKEYS];
    key_st_e          st_d [NKEYS];
    logic [CNT_W-1:0] tmr_q [NKEYS];
    logic [CNT_W-1:0] tmr_d [NKEYS];

    logic [NKEYS-1:0] press;
    logic [NKEYS-1:0] rel;
    logic [NKEYS-1:0] gen;
    logic [1:0]       gen_type [NKEYS];

    logic [NKEYS-1:0] pend_q, pend_d;
    logic [1:0]       pend_type_q [NKEYS];
    logic [1:0]       pend_type_d [NKEYS];

    logic             ev_valid_q, ev_valid_d;
    logic [KEY_W-1:0] ev_key_q, ev_key_d;
    logic [1:0]       ev_type_q, ev_type_d;
    logic             ovf_q, ovf_d;
    logic [KEY_W-1:0] rr_ptr_q, rr_ptr_d;

    logic [KEY_W-1:0] cand [NKEYS];
    logic [KEY_W-1:0] win;
    logic             found;
    logic             load;
    logic [NKEYS-1:0] grant;
    logic             ovf_set;

    assign press = bus.key_flag & ~bus.key_state;
    assign rel   = bus.key_flag &  bus.key_state;

    // ---------------- per-key FSM: state register ----------------
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            for (int i = 0; i < NKEYS; i++) begin
                st_q[i]  <= ST_IDLE;
                tmr_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NKEYS; i++) begin
                st_q[i]  <= st_d[i];
                tmr_q[i] <= tmr_d[i];
            end
        end
    end

    // ---------------- per-key FSM: next state ----------------
    // A release on the terminal-count cycle is checked first so SHORT wins over LONG.
    always_comb begin
        for (int i = 0; i < NKEYS; i++) begin
            st_d[i]  = st_q[i];
            tmr_d[i] = tmr_q[i];
            case (st_q[i])
                ST_IDLE: begin
                    if (press[i]) begin
                        st_d[i]  = ST_PRESSED;
                        tmr_d[i] = '0;
                    end
                end
                ST_PRESSED: begin
                    if (rel[i]) begin
                        st_d[i] = ST_IDLE;
                    end else if (tmr_q[i] == LONG_LAST) begin
                        st_d[i] = ST_HELD;
                    end else begin
                        tmr_d[i] = tmr_q[i] + 1'b1;
                    end
                end
                ST_HELD: begin
                    if (rel[i]) begin
                        st_d[i] = ST_IDLE;
                    end
                end
                default: st_d[i] = ST_IDLE;
            endcase
        end
    end

    // ---------------- per-key FSM: outputs (event generation) ----------------
    always_comb begin
        for (int i = 0; i < NKEYS; i++) begin
            gen[i]      = 1'b0;
            gen_type[i] = 2'b00;
            case (st_q[i])
                ST_PRESSED: begin
                    if (rel[i]) begin
                        gen[i]      = 1'b1;
                        gen_type[i] = EV_SHORT;
                    end else if (tmr_q[i] == LONG_LAST) begin
                        gen[i]      = 1'b1;
                        gen_type[i] = EV_LONG;
                    end
                end
                ST_HELD: begin
                    if (rel[i]) begin
                        gen[i]      = 1'b1;
                        gen_type[i] = EV_LONG_REL;
                    end
                end
                default: begin
                    gen[i]      = 1'b0;
                    gen_type[i] = 2'b00;
                end
            endcase
        end
    end

    // ---------------- round-robin arbiter ----------------
    always_comb begin
        for (int k = 0; k < NKEYS; k++) begin
            cand[k] = KEY_W'((int'(rr_ptr_q) + k) % NKEYS);
        end
    end

    always_comb begin
        win   = '0;
        found = 1'b0;
        for (int k = 0; k < NKEYS; k++) begin
            if (!found && pend_q[cand[k]]) begin
                found = 1'b1;
                win   = cand[k];
            end
        end
        load  = (!ev_valid_q || bus.ev_ready) && found;
        grant = '0;
        if (load) begin
            grant[win] = 1'b1;
        end
    end

    // ---------------- pending slots and overflow ----------------
    // A slot granted this cycle frees up in time to take a new event on the same edge.
    always_comb begin
        pend_d      = pend_q;
        pend_type_d = pend_type_q;
        ovf_set     = 1'b0;
        for (int i = 0; i < NKEYS; i++) begin
            if (grant[i]) begin
                pend_d[i] = 1'b0;
            end
            if (gen[i]) begin
                if (!pend_q[i] || grant[i]) begin
                    pend_d[i]      = 1'b1;
                    pend_type_d[i] = gen_type[i];
                end else begin
                    ovf_set = 1'b1;
                end
            end
        end
        ovf_d = bus.ovf_clr ? 1'b0 : (ovf_q | ovf_set);
    end

    // ---------------- output register ----------------
    always_comb begin
        ev_valid_d = ev_valid_q;
        ev_key_d   = ev_key_q;
        ev_type_d  = ev_type_q;
        rr_ptr_d   = rr_ptr_q;
        if (load) begin
            ev_valid_d = 1'b1;
            ev_key_d   = win;
            ev_type_d  = pend_type_q[win];
            rr_ptr_d   = KEY_W'((int'(win) + 1) % NKEYS);
        end else if (bus.ev_ready) begin
            ev_valid_d = 1'b0;
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            pend_q     <= '0;
            ev_valid_q <= 1'b0;
            ev_key_q   <= '0;
            ev_type_q  <= 2'b00;
            ovf_q      <= 1'b0;
            rr_ptr_q   <= '0;
            for (int i = 0; i < NKEYS; i++) begin
                pend_type_q[i] <= 2'b00;
            end
        end else begin
            pend_q     <= pend_d;
            ev_valid_q <= ev_valid_d;
            ev_key_q   <= ev_key_d;
            ev_type_q  <= ev_type_d;
            ovf_q      <= ovf_d;
            rr_ptr_q   <= rr_ptr_d;
            for (int i = 0; i < NKEYS; i++) begin
                pend_type_q[i] <= pend_type_d[i];
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NKEYS; i++) begin
            bus.dbg_fsm[2*i +: 2] = st_q[i];
        end
    end

    assign bus.ev_valid   = ev_valid_q;
    assign bus.ev_key     = ev_key_q;
    assign bus.ev_type    = ev_type_q;
    assign bus.ovf        = ovf_q;
    assign bus.dbg_rr_ptr = rr_ptr_q;
endmodule

// File: tb/tb_key_event_sched.sv
// Directed bench for key_event_sched: a per-cycle vector table for arbitration and
// overflow, plus hand sequences for the long-hold timing and the mid-hold reset.
module tb_key_event_sched;
    localparam int NKEYS    = 4;
    localparam int KEY_W    = 2;
    localparam int LONG_CNT = 1000;
    localparam logic [1:0] T_SHORT = 2'b01;
    localparam logic [1:0] T_LONG  = 2'b10;
    localparam logic [1:0] T_REL   = 2'b11;

    logic Clk   = 1'b0;
    logic Rst_n = 1'b0;
    always #5 Clk = ~Clk;

    key_event_sched_if #(.NKEYS(NKEYS), .KEY_W(KEY_W)) bus ();

    key_event_sched #(
        .NKEYS(NKEYS), .KEY_W(KEY_W), .LONG_CNT(LONG_CNT), .CNT_W(10)
    ) dut (
        .Clk   (Clk),
        .Rst_n (Rst_n),
        .bus   (bus.master)
    );

    typedef struct {
        logic [3:0] flag;
        logic [3:0] state;
        logic       ready;
        logic       clr;
        logic       exp_valid;
        logic [1:0] exp_key;
        logic [1:0] exp_type;
        logic       exp_ovf;
    } vec_t;

    vec_t       vecs[$];
    int         n_vec = 0;
    int         n_err = 0;
    logic [3:0] lvl;

    function automatic void add(input logic [3:0] f, input logic [3:0] s, input logic r,
                                input logic c, input logic ev, input logic [1:0] ek,
                                input logic [1:0] et, input logic eo);
        vec_t v;
        v.flag = f; v.state = s; v.ready = r; v.clr = c;
        v.exp_valid = ev; v.exp_key = ek; v.exp_type = et; v.exp_ovf = eo;
        vecs.push_back(v);
    endfunction

    // Drive at the falling edge, let the rising edge sample, look 1 ns later.
    task automatic step(input logic [3:0] f, input logic [3:0] s, input logic r, input logic c);
        @(negedge Clk);
        bus.key_flag  = f;
        bus.key_state = s;
        bus.ev_ready  = r;
        bus.ovf_clr   = c;
        @(posedge Clk);
        #1;
    endtask

    task automatic check(input string name, input logic ev, input logic [1:0] ek,
                         input logic [1:0] et, input logic eo);
        logic ok;
        n_vec++;
        ok = (bus.ev_valid === ev) && (bus.ovf === eo) &&
             (!ev || (bus.ev_key === ek && bus.ev_type === et));
        if (!ok) begin
            n_err++;
            $display("FAIL %s: got valid=%0b key=%0d type=%b ovf=%0b, want valid=%0b key=%0d type=%b ovf=%0b",
                     name, bus.ev_valid, bus.ev_key, bus.ev_type, bus.ovf, ev, ek, et, eo);
        end
    endtask

    task automatic check_reset(input string name);
        n_vec++;
        if (bus.ev_valid !== 1'b0 || bus.ev_key !== 2'd0 || bus.ev_type !== 2'b00 ||
            bus.ovf !== 1'b0 || bus.dbg_rr_ptr !== 2'd0 || bus.dbg_fsm !== 8'h00) begin
            n_err++;
            $display("FAIL %s: got valid=%0b key=%0d type=%b ovf=%0b rr=%0d fsm=%h, want all zero",
                     name, bus.ev_valid, bus.ev_key, bus.ev_type, bus.ovf, bus.dbg_rr_ptr, bus.dbg_fsm);
        end
    endtask

    task automatic key_press(input int i);
        lvl[i] = 1'b0;
        step(4'(1 << i), lvl, 1'b1, 1'b0);
    endtask

    task automatic key_release(input int i);
        lvl[i] = 1'b1;
        step(4'(1 << i), lvl, 1'b1, 1'b0);
    endtask

    task automatic idle();
        step(4'h0, lvl, 1'b1, 1'b0);
    endtask

    initial begin
        lvl           = 4'hF;
        bus.key_flag  = 4'h0;
        bus.key_state = 4'hF;
        bus.ev_ready  = 1'b1;
        bus.ovf_clr   = 1'b0;

        // all four keys SHORT together: from rr_ptr=0, then from rr_ptr=2 after a key1 event
        add(4'hF, 4'h0, 1, 0, 0, 0, 2'b00, 0);
        add(4'hF, 4'hF, 1, 0, 0, 0, 2'b00, 0);
        add(4'h0, 4'hF, 1, 0, 1, 0, T_SHORT, 0);
        add(4'h0, 4'hF, 1, 0, 1, 1, T_SHORT, 0);
        add(4'h0, 4'hF, 1, 0, 1, 2, T_SHORT, 0);
        add(4'h0, 4'hF, 1, 0, 1, 3, T_SHORT, 0);
        add(4'h0, 4'hF, 1, 0, 0, 0, 2'b00, 0);
        add(4'h2, 4'hD, 1, 0, 0, 0, 2'b00, 0);
        add(4'h2, 4'hF, 1, 0, 0, 0, 2'b00, 0);
        add(4'h0, 4'hF, 1, 0, 1, 1, T_SHORT, 0);
        add(4'h0, 4'hF, 1, 0, 0, 0, 2'b00, 0);
        add(4'hF, 4'h0, 1, 0, 0, 0, 2'b00, 0);
        add(4'hF, 4'hF, 1, 0, 0, 0, 2'b00, 0);
        add(4'h0, 4'hF, 1, 0, 1, 2, T_SHORT, 0);
        add(4'h0, 4'hF, 1, 0, 1, 3, T_SHORT, 0);
        add(4'h0, 4'hF, 1, 0, 1, 0, T_SHORT, 0);
        add(4'h0, 4'hF, 1, 0, 1, 1, T_SHORT, 0);
        add(4'h0, 4'hF, 1, 0, 0, 0, 2'b00, 0);
        // back-pressure on key1: one on the port, one queued, third overflows, then clear
        add(4'h2, 4'hD, 0, 0, 0, 0, 2'b00, 0);
        add(4'h2, 4'hF, 0, 0, 0, 0, 2'b00, 0);
        add(4'h0, 4'hF, 0, 0, 1, 1, T_SHORT, 0);
        add(4'h2, 4'hD, 0, 0, 1, 1, T_SHORT, 0);
        add(4'h2, 4'hF, 0, 0, 1, 1, T_SHORT, 0);
        add(4'h2, 4'hD, 0, 0, 1, 1, T_SHORT, 0);
        add(4'h2, 4'hF, 0, 0, 1, 1, T_SHORT, 1);
        add(4'h0, 4'hF, 0, 1, 1, 1, T_SHORT, 0);
        add(4'h0, 4'hF, 0, 0, 1, 1, T_SHORT, 0);
        add(4'h0, 4'hF, 1, 0, 1, 1, T_SHORT, 0);
        add(4'h0, 4'hF, 1, 0, 0, 0, 2'b00, 0);
        // key0: clear wins over a same-cycle overflow; a granted slot accepts a new event
        add(4'h1, 4'hE, 0, 0, 0, 0, 2'b00, 0);
        add(4'h1, 4'hF, 0, 0, 0, 0, 2'b00, 0);
        add(4'h0, 4'hF, 0, 0, 1, 0, T_SHORT, 0);
        add(4'h1, 4'hE, 0, 0, 1, 0, T_SHORT, 0);
        add(4'h1, 4'hF, 0, 0, 1, 0, T_SHORT, 0);
        add(4'h1, 4'hE, 0, 0, 1, 0, T_SHORT, 0);
        add(4'h1, 4'hF, 0, 1, 1, 0, T_SHORT, 0);
        add(4'h1, 4'hE, 0, 0, 1, 0, T_SHORT, 0);
        add(4'h1, 4'hF, 1, 0, 1, 0, T_SHORT, 0);
        add(4'h0, 4'hF, 1, 0, 1, 0, T_SHORT, 0);
        add(4'h0, 4'hF, 1, 0, 0, 0, 2'b00, 0);

        repeat (3) @(posedge Clk);
        #1;
        check_reset("reset_values");
        @(negedge Clk);
        Rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].flag, vecs[i].state, vecs[i].ready, vecs[i].clr);
            check($sformatf("vec%0d", i), vecs[i].exp_valid, vecs[i].exp_key,
                  vecs[i].exp_type, vecs[i].exp_ovf);
        end

        // key0 short press: event one cycle after the release flag
        key_press(0);
        for (int n = 1; n < 100; n++) begin
            idle();
            check("t1_hold", 0, 0, 2'b00, 0);
        end
        key_release(0);
        check("t1_rel_edge", 0, 0, 2'b00, 0);
        idle();
        check("t1_short", 1, 0, T_SHORT, 0);
        repeat (3) begin
            idle();
            check("t1_after", 0, 0, 2'b00, 0);
        end

        // key2 held 1500 cycles: LONG, then LONG_REL on release
        key_press(2);
        for (int n = 1; n <= 1000; n++) begin
            idle();
            check("t2_hold", 0, 0, 2'b00, 0);
        end
        idle();
        check("t2_long", 1, 2, T_LONG, 0);
        for (int n = 1002; n < 1500; n++) begin
            idle();
            check("t2_held", 0, 0, 2'b00, 0);
        end
        key_release(2);
        check("t2_rel_edge", 0, 0, 2'b00, 0);
        idle();
        check("t2_long_rel", 1, 2, T_REL, 0);
        idle();
        check("t2_after", 0, 0, 2'b00, 0);

        // key1 released on the terminal-count cycle: SHORT only
        key_press(1);
        for (int n = 1; n <= 999; n++) begin
            idle();
            check("t3_hold", 0, 0, 2'b00, 0);
        end
        key_release(1);
        check("t3_rel_edge", 0, 0, 2'b00, 0);
        idle();
        check("t3_short", 1, 1, T_SHORT, 0);
        repeat (5) begin
            idle();
            check("t3_no_long", 0, 0, 2'b00, 0);
        end

        // reset in the middle of a key3 hold; the later release must be ignored
        key_press(3);
        repeat (50) idle();
        @(negedge Clk);
        Rst_n = 1'b0;
        #1;
        check_reset("t6_async_reset");
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        Rst_n = 1'b1;
        key_release(3);
        check("t6_rel_edge", 0, 0, 2'b00, 0);
        repeat (5) begin
            idle();
            check("t6_no_event", 0, 0, 2'b00, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
